// File: rtl/counter_chk_pkg.sv
// Shared types for the up/down counter checker.
// Holds the state encoding, the sample bundle and prediction helpers.
package counter_chk_pkg;

    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        FAULT   = 2'd2
    } chk_state_t;

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             mode;
        logic             rst;
    } sample_t;

    // Value the counter must show on the sample after s.
    function automatic logic [CNT_W-1:0] predict(sample_t s);
        logic [CNT_W-1:0] nxt;
        if (s.rst)
            nxt = '0;
        else if (s.mode)
            nxt = s.cnt + CNT_W'(1);
        else
            nxt = s.cnt - CNT_W'(1);
        return nxt;
    endfunction

    // True when the step after s crosses the modulus boundary.
    function automatic logic is_wrap(sample_t s);
        logic up_w;
        logic dn_w;
        up_w = s.mode & (&s.cnt);
        dn_w = ~s.mode & ~(|s.cnt);
        return ~s.rst & (up_w | dn_w);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating statistics counter.
// A clear request beats a same-cycle increment.
module sat_counter #(
    parameter int SW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [SW-1:0] q
);

    // Count up to all-ones and hold; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + SW'(1);
    end

endmodule

// File: rtl/counter_checker.sv
// Passive observer for an up/down counter interface.
// Predicts each next count, flags mismatches/wraps, relocks after faults.
module counter_checker
    import counter_chk_pkg::*;
#(
    parameter int W      = CNT_W,
    parameter int RELOCK = 4,
    parameter int SW     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          obs_valid,
    input  logic [W-1:0]  obs_cnt,
    input  logic          obs_mode,
    input  logic          obs_rst,
    input  logic          clr_stats,
    output logic          locked,
    output logic          err_pulse,
    output logic          err_sticky,
    output logic          wrap_pulse,
    output logic [SW-1:0] err_cnt,
    output logic [SW-1:0] wrap_cnt
);

    localparam int RW = (RELOCK > 1) ? $clog2(RELOCK) : 1;
    localparam logic [RW-1:0] RUN_LAST = RW'(RELOCK - 1);

    chk_state_t    state_q;
    chk_state_t    state_d;
    logic [RW-1:0] run_q;
    logic [RW-1:0] run_d;
    sample_t       p_q;
    sample_t       smp;
    logic [W-1:0]  exp_q;
    logic          match;
    logic          mis;
    logic          wrap;

    assign smp   = '{cnt: obs_cnt, mode: obs_mode, rst: obs_rst};
    assign match = (obs_cnt == exp_q);

    // Next state, match-run and event decode for the current sample.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        mis     = 1'b0;
        wrap    = 1'b0;
        if (obs_valid) begin
            unique case (state_q)
                ACQUIRE: begin
                    state_d = TRACK;
                end
                TRACK: begin
                    if (match) begin
                        wrap = is_wrap(p_q);
                    end else begin
                        mis     = 1'b1;
                        state_d = FAULT;
                        run_d   = '0;
                    end
                end
                FAULT: begin
                    if (!match) begin
                        mis   = 1'b1;
                        run_d = '0;
                    end else if (run_q == RUN_LAST) begin
                        state_d = TRACK;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + RW'(1);
                    end
                end
                default: begin
                    state_d = ACQUIRE;
                    run_d   = '0;
                end
            endcase
        end
    end

    // FSM state and consecutive-match run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACQUIRE;
            run_q   <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // Every valid sample reseeds the previous sample and prediction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            exp_q <= '0;
        end else if (obs_valid) begin
            p_q   <= smp;
            exp_q <= predict(smp);
        end
    end

    // One-cycle event pulses and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            err_pulse  <= mis;
            wrap_pulse <= wrap;
            if (clr_stats)
                err_sticky <= 1'b0;
            else if (mis)
                err_sticky <= 1'b1;
        end
    end

    sat_counter #(.SW(SW)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mis),
        .clr   (clr_stats),
        .q     (err_cnt)
    );

    sat_counter #(.SW(SW)) u_wrap_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wrap),
        .clr   (clr_stats),
        .q     (wrap_cnt)
    );

    assign locked = (state_q == TRACK);

endmodule

// File: tb/tb_counter_checker.sv
// Self-checking bench for counter_checker.
// Behavioural model plus directed literal checks and random traffic.
module tb_counter_checker;

    localparam int W      = 10;
    localparam int RELOCK = 4;
    localparam int SW     = 8;
    localparam int MOD    = 1 << W;
    localparam int SMAX   = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          obs_valid;
    logic [W-1:0]  obs_cnt;
    logic          obs_mode;
    logic          obs_rst;
    logic          clr_stats;
    logic          locked;
    logic          err_pulse;
    logic          err_sticky;
    logic          wrap_pulse;
    logic [SW-1:0] err_cnt;
    logic [SW-1:0] wrap_cnt;

    counter_checker #(.W(W), .RELOCK(RELOCK), .SW(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .obs_valid  (obs_valid),
        .obs_cnt    (obs_cnt),
        .obs_mode   (obs_mode),
        .obs_rst    (obs_rst),
        .clr_stats  (clr_stats),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .wrap_pulse (wrap_pulse),
        .err_cnt    (err_cnt),
        .wrap_cnt   (wrap_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Model: previous sample seen, lock status, run of matches, outputs.
    bit m_have;
    bit m_locked;
    int m_run;
    int pc;
    bit pm;
    bit pr;
    bit e_err;
    bit e_wrap;
    bit e_sticky;
    int e_errcnt;
    int e_wrapcnt;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pred();
        if (pr) return 0;
        return pm ? (pc + 1) % MOD : (pc + MOD - 1) % MOD;
    endfunction

    function automatic bit legal_wrap();
        if (pr) return 1'b0;
        return pm ? (pc == MOD - 1) : (pc == 0);
    endfunction

    task automatic model_reset();
        m_have = 0; m_locked = 0; m_run = 0;
        pc = 0; pm = 0; pr = 0;
        e_err = 0; e_wrap = 0; e_sticky = 0;
        e_errcnt = 0; e_wrapcnt = 0;
    endtask

    task automatic model_step(input bit v, input int c, input bit m,
                              input bit r, input bit clr);
        e_err  = 0;
        e_wrap = 0;
        if (v) begin
            if (!m_have) begin
                m_have   = 1;
                m_locked = 1;
            end else if (m_locked) begin
                if (c == pred()) begin
                    e_wrap = legal_wrap();
                end else begin
                    e_err    = 1;
                    m_locked = 0;
                    m_run    = 0;
                end
            end else begin
                if (c == pred()) begin
                    m_run++;
                    if (m_run == RELOCK) begin
                        m_locked = 1;
                        m_run    = 0;
                    end
                end else begin
                    e_err = 1;
                    m_run = 0;
                end
            end
            pc = c; pm = m; pr = r;
        end
        if (e_err) begin
            e_sticky = 1;
            if (e_errcnt < SMAX) e_errcnt++;
        end
        if (e_wrap && e_wrapcnt < SMAX) e_wrapcnt++;
        if (clr) begin
            e_errcnt = 0; e_wrapcnt = 0; e_sticky = 0;
        end
    endtask

    // Compare every DUT output with the model on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("locked", int'(locked), int'(m_locked));
            chk("err_pulse", int'(err_pulse), int'(e_err));
            chk("err_sticky", int'(err_sticky), int'(e_sticky));
            chk("wrap_pulse", int'(wrap_pulse), int'(e_wrap));
            chk("err_cnt", int'(err_cnt), e_errcnt);
            chk("wrap_cnt", int'(wrap_cnt), e_wrapcnt);
        end
    end

    // Drive one cycle; called at posedge+1, returns at next posedge+1.
    task automatic cyc(input bit v, input int c, input bit m,
                       input bit r, input bit clr);
        obs_valid = v;
        obs_cnt   = W'(c);
        obs_mode  = m;
        obs_rst   = r;
        clr_stats = clr;
        @(posedge clk);
        if (rst_n) model_step(v, c, m, r, clr);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        obs_valid = 1'b0;
        obs_cnt   = '0;
        obs_mode  = 1'b0;
        obs_rst   = 1'b0;
        clr_stats = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_locked", int'(locked), 0);
        chk("reset_errcnt", int'(err_cnt), 0);
        chk_en = 1'b1;
        do_reset();

        // Lock on a clean up-count.
        cyc(1, 5, 1, 0, 0);
        cyc(1, 6, 1, 0, 0);
        cyc(1, 7, 1, 0, 0);
        chk("t1_locked", int'(locked), 1);
        chk("t1_errcnt", int'(err_cnt), 0);

        // Up wrap, then down wrap.
        do_reset();
        cyc(1, 1021, 1, 0, 0);
        cyc(1, 1022, 1, 0, 0);
        cyc(1, 1023, 1, 0, 0);
        cyc(1, 0, 1, 0, 0);
        chk("t2_wrap_pulse", int'(wrap_pulse), 1);
        cyc(1, 1, 0, 0, 0);
        chk("t2_wrap_cnt1", int'(wrap_cnt), 1);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1023, 0, 0, 0);
        chk("t2_wrap_cnt2", int'(wrap_cnt), 2);
        chk("t2_errcnt", int'(err_cnt), 0);

        // Mismatch, then relock after RELOCK matches.
        do_reset();
        cyc(1, 10, 1, 0, 0);
        cyc(1, 11, 1, 0, 0);
        cyc(1, 15, 1, 0, 0);
        chk("t3_err_pulse", int'(err_pulse), 1);
        chk("t3_sticky", int'(err_sticky), 1);
        chk("t3_unlocked", int'(locked), 0);
        cyc(1, 16, 1, 0, 0);
        cyc(1, 17, 1, 0, 0);
        cyc(1, 18, 1, 0, 0);
        chk("t3_still_fault", int'(locked), 0);
        cyc(1, 19, 1, 0, 0);
        chk("t3_relocked", int'(locked), 1);
        chk("t3_errcnt", int'(err_cnt), 1);

        // Observed counter reset.
        do_reset();
        cyc(1, 299, 1, 0, 0);
        cyc(1, 300, 1, 1, 0);
        cyc(1, 0, 1, 0, 0);
        chk("t4_rst_ok", int'(err_cnt), 0);
        cyc(1, 1, 1, 1, 0);
        cyc(1, 2, 1, 0, 0);
        chk("t4_rst_bad", int'(err_cnt), 1);

        // Gap then mode flip.
        do_reset();
        cyc(1, 39, 1, 0, 0);
        cyc(1, 40, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 777, 0, 1, 0);
        cyc(1, 41, 0, 0, 0);
        cyc(1, 40, 0, 0, 0);
        chk("t5_errcnt", int'(err_cnt), 0);
        chk("t5_locked", int'(locked), 1);

        // Saturation, clear-vs-increment, async reset mid-fault.
        do_reset();
        cyc(1, 500, 1, 0, 0);
        for (int i = 0; i < 300; i++) cyc(1, 500, 1, 0, 0);
        chk("t6_sat", int'(err_cnt), 255);
        cyc(1, 500, 1, 0, 1);
        chk("t6_clr_cnt", int'(err_cnt), 0);
        chk("t6_clr_pulse", int'(err_pulse), 1);
        cyc(1, 500, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_ar_locked", int'(locked), 0);
        chk("t6_ar_pulse", int'(err_pulse), 0);
        chk("t6_ar_sticky", int'(err_sticky), 0);
        chk("t6_ar_errcnt", int'(err_cnt), 0);
        model_reset();
        cyc(0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // Random traffic mostly following the counter.
        for (int i = 0; i < 3000; i++) begin
            bit v;
            bit m;
            bit r;
            bit clr;
            int c;
            int k;
            v   = ($urandom_range(0, 7) != 0);
            m   = ($urandom_range(0, 9) == 0) ? ~pm : pm;
            r   = ($urandom_range(0, 24) == 0);
            clr = ($urandom_range(0, 60) == 0);
            k   = $urandom_range(0, 19);
            if (!m_have || k == 0)
                c = $urandom_range(0, MOD - 1);
            else if (k == 1)
                c = m ? MOD - 2 : 1;
            else
                c = pred();
            cyc(v, c, m, r, clr);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
